instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory, one-deep fetch pipeline and prefetch queue.
// Optional perf counters (pop count, stall count) are enabled by IFETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_ins,
  output logic [ADDR_W-1:0] out_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem [2**ADDR_W];
  logic [WIDTH-1:0]  q_ins [DEPTH];
  logic [ADDR_W-1:0] q_pc  [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_p0;
  logic [WIDTH-1:0]  ins_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              issue;
  logic              push;
  logic              pop;

  // In-flight fetches reserve a queue slot so the queue can never overflow.
  assign issue = rst_n && !redirect_valid &&
                 ((count + CNT_W'(vld_p1)) < CNT_W'(DEPTH));
  assign push  = vld_p1 && !redirect_valid;
  assign pop   = (count != '0) && out_ready && !redirect_valid;

  assign out_valid = (count != '0);
  assign out_ins   = out_valid ? q_ins[rd_ptr] : '0;
  assign out_pc    = out_valid ? q_pc[rd_ptr]  : '0;

  // Stage p0 -> p1: program load and synchronous read (old word on collision).
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (issue) begin
      ins_p1 <= mem[fetch_pc_p0];
      pc_p1  <= fetch_pc_p0;
    end
  end

  // Stage p1 -> queue: data storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[wr_ptr] <= ins_p1;
      q_pc[wr_ptr]  <= pc_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_p0 <= ADDR_W'(RESET_PC);
      vld_p1      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= redirect_pc;
      vld_p1      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + 1'b1;
      vld_p1 <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (pop) perf_fetch <= perf_fetch + 1'b1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
